// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops bytes from a first-word-fall-through FIFO and packs
// PACK consecutive lanes (lane 0 first, little-endian) into one output word.
// The word is presented with a valid/ready handshake. A flush pulse ends a
// partial word early and marks it with m_last. word_count counts accepted
// output words and wraps at 16 bits.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       rd_clk,
    input  logic                       reset_n,
    input  logic                       fifo_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last,
    output logic [15:0]                word_count
);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] OUT  = 1'b1;

    // Lane index is 4 bits wide, which is enough for up to 8 lanes.
    localparam logic [3:0] LAST_LANE = 4'(PACK - 1);

    logic [0:0]               state_r;
    logic [3:0]               lane_r;
    logic [DATA_WIDTH*PACK-1:0] data_r;
    logic [PACK-1:0]          keep_r;
    logic                     last_r;
    logic                     valid_r;
    logic [15:0]              count_r;

    logic                     rd_en_s;
    logic [DATA_WIDTH*PACK-1:0] data_cap_s;
    logic [PACK-1:0]          keep_cap_s;

    logic [0:0]               state_nxt_s;
    logic [3:0]               lane_nxt_s;
    logic [DATA_WIDTH*PACK-1:0] data_nxt_s;
    logic [PACK-1:0]          keep_nxt_s;
    logic                     last_nxt_s;
    logic                     valid_nxt_s;
    logic [15:0]              count_nxt_s;

    // Pop request: only while collecting, FIFO has data, and not in reset.
    always_comb begin
        rd_en_s = (state_r == FILL) && !fifo_empty && reset_n;
    end

    // Merge the FIFO head into the current lane when it is popped this cycle.
    always_comb begin
        data_cap_s = data_r;
        keep_cap_s = keep_r;
        for (int i = 0; i < PACK; i++) begin
            data_cap_s[i*DATA_WIDTH +: DATA_WIDTH] =
                (rd_en_s && (lane_r == 4'(i))) ? fifo_rd_data
                                               : data_r[i*DATA_WIDTH +: DATA_WIDTH];
            keep_cap_s[i] = keep_r[i] | (rd_en_s && (lane_r == 4'(i)));
        end
    end

    // FILL/OUT sequencing, word termination and handshake bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        lane_nxt_s  = lane_r;
        data_nxt_s  = data_r;
        keep_nxt_s  = keep_r;
        last_nxt_s  = last_r;
        valid_nxt_s = valid_r;
        count_nxt_s = count_r;
        case (state_r)
            FILL: begin
                data_nxt_s = data_cap_s;
                keep_nxt_s = keep_cap_s;
                if (rd_en_s && (lane_r == LAST_LANE)) begin
                    // Final lane captured; a coincident flush still marks last.
                    state_nxt_s = OUT;
                    valid_nxt_s = 1'b1;
                    last_nxt_s  = flush;
                    lane_nxt_s  = 4'd0;
                end else if (flush && (keep_cap_s != {PACK{1'b0}})) begin
                    // Early termination; an empty flush is simply dropped.
                    state_nxt_s = OUT;
                    valid_nxt_s = 1'b1;
                    last_nxt_s  = 1'b1;
                    lane_nxt_s  = 4'd0;
                end else begin
                    lane_nxt_s = rd_en_s ? (lane_r + 4'd1) : lane_r;
                end
            end
            OUT: begin
                if (valid_r && m_ready) begin
                    state_nxt_s = FILL;
                    valid_nxt_s = 1'b0;
                    data_nxt_s  = {(DATA_WIDTH*PACK){1'b0}};
                    keep_nxt_s  = {PACK{1'b0}};
                    last_nxt_s  = 1'b0;
                    count_nxt_s = count_r + 16'd1;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = FILL;
                lane_nxt_s  = 4'd0;
                data_nxt_s  = {(DATA_WIDTH*PACK){1'b0}};
                keep_nxt_s  = {PACK{1'b0}};
                last_nxt_s  = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset discarding any word.
    always_ff @(posedge rd_clk) begin
        if (!reset_n) begin
            state_r <= FILL;
            lane_r  <= 4'd0;
            data_r  <= {(DATA_WIDTH*PACK){1'b0}};
            keep_r  <= {PACK{1'b0}};
            last_r  <= 1'b0;
            valid_r <= 1'b0;
            count_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            lane_r  <= lane_nxt_s;
            data_r  <= data_nxt_s;
            keep_r  <= keep_nxt_s;
            last_r  <= last_nxt_s;
            valid_r <= valid_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = valid_r;
    assign m_data     = data_r;
    assign m_keep     = keep_r;
    assign m_last     = last_r;
    assign word_count = count_r;

endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO byte-lane width in bits.
REQ-002 The block SHALL have parameter PACK, default 4, giving the number of lanes per output word (legal range 2..8).
REQ-003 The block SHALL have port rd_clk, input, 1 bit: the single clock, which is the FIFO read-domain clock.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: the FIFO empty flag.
REQ-006 The block SHALL have port fifo_rd_data, input, DATA_WIDTH bits: the FIFO head entry, first-word-fall-through, valid whenever fifo_empty=0.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: pops the FIFO head on the rising edge where it is high.
REQ-008 The block SHALL have port flush, input, 1 bit: a single-cycle request to terminate the current partial word.
REQ-009 The block SHALL have port m_valid, output, 1 bit: the output word is valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: the sink accepts the output word.
REQ-011 The block SHALL have port m_data, output, DATA_WIDTH*PACK bits: the packed word.
REQ-012 The block SHALL have port m_keep, output, PACK bits: per-lane valid mask.
REQ-013 The block SHALL have port m_last, output, 1 bit: the word was terminated by flush.
REQ-014 The block SHALL have port word_count, output, 16 bits: count of words accepted at the output.

Function
REQ-015 The block SHALL use two states: FILL (collecting lanes) and OUT (holding a word until m_ready).
REQ-016 fifo_rd_en SHALL be combinational and equal to (state==FILL) && !fifo_empty && reset_n.
REQ-017 On each rd_clk edge with fifo_rd_en=1, the block SHALL write fifo_rd_data into lane index L (bits [L*DATA_WIDTH +: DATA_WIDTH]), set m_keep[L], and increment L; lane 0 is the first byte, so packing is little-endian.
REQ-018 When the captured lane is PACK-1, the block SHALL go to OUT on that edge, with m_valid=1 from the next cycle, m_keep all ones, m_last=0, and L reset to 0.
REQ-019 In FILL, flush=1 SHALL cause a transition to OUT on that edge if the number of filled lanes, counting any lane captured on the same edge, is at least 1; in that case m_last=1 and m_keep reflects the filled lanes.
REQ-020 Flush coincident with capture of lane PACK-1 SHALL produce a full word (m_keep all ones) with m_last=1.
REQ-021 Flush in FILL with zero lanes filled and fifo_empty=1 SHALL have no effect and produce no zero-length word.
REQ-022 Flush in OUT SHALL be ignored.
REQ-023 In OUT, m_data, m_keep and m_last SHALL remain stable and fifo_rd_en SHALL be 0 until m_valid && m_ready.
REQ-024 On m_valid && m_ready, the block SHALL return to FILL, clear m_valid, m_keep, m_last and m_data, and increment word_count by 1, wrapping 0xFFFF->0x0000.
REQ-025 Lane capture SHALL NOT occur on the handshake edge; the first capture of the next word is possible on the following edge.
REQ-026 Latency SHALL be 1 cycle from the capturing edge of the final lane (or the flush edge) to m_valid=1.
REQ-027 Sustained throughput SHALL be PACK+1 cycles per word when m_ready=1.
REQ-028 m_valid SHALL NOT depend combinationally on m_ready.
REQ-029 Unused lanes of a partial word SHALL read as 0 in m_data.

Reset
REQ-030 When reset_n=0 at a rising edge of rd_clk, the block SHALL enter FILL with L=0 and m_valid, m_data, m_keep, m_last and word_count all 0.
REQ-031 fifo_rd_en SHALL be 0 whenever reset_n=0.
REQ-032 Reset asserted in any state, mid-word or in OUT, SHALL discard the partial or pending word without a handshake and without incrementing word_count.

Verification
REQ-033 A bench SHALL cover: PACK=4, FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> four pops on consecutive edges, then m_valid=1 for 1 cycle with m_data=0x44332211, m_keep=4'b1111, m_last=0, word_count=1.
REQ-034 A bench SHALL cover: bytes 0xAA,0xBB followed by FIFO empty, then a flush pulse -> m_data=0x0000BBAA, m_keep=4'b0011, m_last=1.
REQ-035 A bench SHALL cover: flush coincident with the pop of the 4th byte 0x04 after 0x01..0x03 -> m_data=0x04030201, m_keep=4'b1111, m_last=1; flush with L=0 and FIFO empty -> no m_valid.
REQ-036 A bench SHALL cover: m_ready=0 for 10 cycles with the FIFO non-empty -> fifo_rd_en=0 and the output stable throughout; m_ready=1 -> handshake, then popping resumes on the next edge.
REQ-037 A bench SHALL cover: reset_n=0 for 1 cycle after 2 bytes are captured, or while in OUT -> m_valid=0, m_keep=0, word_count=0, and the next word starts at lane 0.
REQ-038 A bench SHALL cover: word_count preset by 65535 handshakes, then one more -> word_count=0x0000.
